// File: rtl/store_unit_if.sv
// Store request / data-memory write bundle.
// slave = store unit side, master = core and memory side.
interface store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic [1:0]            st_op;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_wstrb;
    logic                  mem_ack;
    logic                  st_done;
    logic                  st_err;

    modport slave (
        input  st_valid, st_addr, st_data, st_op, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb,
        output st_done, st_err
    );

    modport master (
        output st_valid, st_addr, st_data, st_op, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb,
        input  st_done, st_err
    );
endinterface

// File: rtl/store_unit.sv
// Store narrowing unit: lane placement, strobes and
// two-beat split of stores that cross a memory word.
module store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    store_unit_if.slave   bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ0 = 2'd1;
    localparam logic [1:0] S_REQ1 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b10;

    logic [1:0]            r_state;
    logic                  r_err;
    logic                  r_span;
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic [DATA_WIDTH-1:0] r_b1_wdata;
    logic [NB-1:0]         r_b1_wstrb;

    logic [OW-1:0]           w_off;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [NB-1:0]           w_mask;
    logic [DATA_WIDTH-1:0]   w_mdata;
    logic [2*DATA_WIDTH-1:0] w_wide;
    logic [2*NB-1:0]         w_strb;
    logic                    w_illegal;
    logic                    w_accept;

    assign w_off     = bus.st_addr[OW-1:0];
    assign w_base    = {bus.st_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
    assign w_illegal = (bus.st_op == 2'b11);
    assign w_accept  = bus.st_valid && (r_state == S_IDLE);

    // Byte-lane mask of the store size, starting at lane 0.
    always_comb begin
        w_mask = '0;
        case (bus.st_op)
            ST_B:    w_mask = NB'(1);
            ST_H:    w_mask = NB'(3);
            ST_W:    w_mask = NB'(15);
            default: w_mask = '0;
        endcase
    end

    // Keep only the bytes being stored; the rest become zero.
    always_comb begin
        w_mdata = '0;
        for (int i = 0; i < NB; i++) begin
            w_mdata[8*i +: 8] = w_mask[i] ? bus.st_data[8*i +: 8] : 8'h00;
        end
    end

    // Double-width shift: low half is beat 0, high half spills into beat 1.
    assign w_wide = {{DATA_WIDTH{1'b0}}, w_mdata} << {w_off, 3'b000};
    assign w_strb = {{NB{1'b0}}, w_mask} << w_off;

    // Control FSM and registered memory beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b0;
            r_span     <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_b1_wdata <= '0;
            r_b1_wstrb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_err <= w_illegal;
                        if (w_illegal) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state    <= S_REQ0;
                            r_req      <= 1'b1;
                            r_addr     <= w_base;
                            r_wdata    <= w_wide[DATA_WIDTH-1:0];
                            r_wstrb    <= w_strb[NB-1:0];
                            r_b1_wdata <= w_wide[2*DATA_WIDTH-1:DATA_WIDTH];
                            r_b1_wstrb <= w_strb[2*NB-1:NB];
                            r_span     <= |w_strb[2*NB-1:NB];
                        end
                    end
                end
                S_REQ0: begin
                    if (bus.mem_ack) begin
                        if (r_span) begin
                            r_state <= S_REQ1;
                            r_addr  <= r_addr + ADDR_WIDTH'(NB);
                            r_wdata <= r_b1_wdata;
                            r_wstrb <= r_b1_wstrb;
                        end else begin
                            r_state <= S_RESP;
                            r_req   <= 1'b0;
                        end
                    end
                end
                S_REQ1: begin
                    if (bus.mem_ack) begin
                        r_state <= S_RESP;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.st_ready  = (r_state == S_IDLE);
    assign bus.st_done   = (r_state == S_RESP);
    assign bus.st_err    = (r_state == S_RESP) && r_err;
    assign bus.mem_req   = r_req;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wstrb = r_wstrb;
endmodule

// File: doc/store_unit.md
# store_unit

Store-side data narrowing unit: the write-direction counterpart of `signext`. `signext` widens narrow memory and immediate values to `DATA_WIDTH`; `store_unit` narrows a `DATA_WIDTH` register value to a byte, halfword or word. It places the result on the correct byte lanes of a word-addressed data memory and generates the write strobes. Stores that cross a word boundary are split into two memory beats over a valid/ready-style request/acknowledge handshake. It sits between the execute stage and the data memory port.

## Interface
- `DATA_WIDTH`, 32, register and memory word width; must be 32 or 64. `NB = DATA_WIDTH/8` lanes, `OW = $clog2(NB)` offset bits.
- `ADDR_WIDTH`, 32, byte-address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `st_valid` in 1: store request from core.
- `st_ready` out 1: unit idle, request accepted this cycle if `st_valid`.
- `st_addr` in ADDR_WIDTH: byte address.
- `st_data` in DATA_WIDTH: register value; low bytes are used.
- `st_op` in 2: `isa_shared::ST_B`=2'b00, `ST_H`=2'b01, `ST_W`=2'b10; 2'b11 is illegal.
- `mem_req` out 1: memory write beat valid.
- `mem_addr` out ADDR_WIDTH: word-aligned address (low OW bits 0).
- `mem_wdata` out DATA_WIDTH: lane-placed data; unstrobed lanes are 0.
- `mem_wstrb` out NB: byte-lane write enables.
- `mem_ack` in 1: beat accepted; sampled only while `mem_req`=1.
- `st_done` out 1: one-cycle completion pulse.
- `st_err` out 1: asserted with `st_done` for an illegal `st_op`.

## Operation
- **Size.** SIZE = 1, 2 or 4 bytes for B, H or W. W is the low 32 bits even when `DATA_WIDTH`=64.
- **Offset.** OFF = `st_addr[OW-1:0]`, BASE = `st_addr` with low OW bits cleared.
- **Capture.** Accept when `st_valid && st_ready`. Address, data and op are captured; inputs are don't-care afterwards.
- **States:**
  - IDLE: `st_ready`=1.
  - REQ0
  - REQ1
  - RESP: `st_done`=1 for exactly one cycle.
- **Transitions:**
  - IDLE→REQ0 on accept with a legal op.
  - IDLE→RESP on accept with an illegal op. `st_err`=1, no `mem_req`.
  - REQ0→REQ1 on `mem_ack` if OFF+SIZE > NB (spanning).
  - REQ0→RESP on `mem_ack` otherwise.
  - REQ1→RESP on `mem_ack`.
  - RESP→IDLE unconditionally.
- **Beat 0:**
  - `mem_addr`=BASE.
  - `mem_wdata` = (`st_data` masked to SIZE bytes) << (8·OFF).
  - `mem_wstrb` = ((1<<SIZE)−1) << OFF, truncated to NB bits.
- **Beat 1:**
  - `mem_addr` = BASE+NB, modulo 2^ADDR_WIDTH (wraps).
  - `mem_wdata` = masked data >> (8·(NB−OFF)).
  - `mem_wstrb` = ((1<<SIZE)−1) >> (NB−OFF).
- **Request stability.** `mem_req`, `mem_addr`, `mem_wdata` and `mem_wstrb` are registered. They are held stable from the first cycle of a beat until the cycle `mem_ack` is seen. The unit never deasserts `mem_req` without an ack.
- **Spurious ack.** `mem_ack` while `mem_req`=0 is ignored.
- **Byte stores** never span. A halfword spans only at OFF=NB−1. A word spans at any OFF > NB−4.
- **Error handling.** Misalignment is not an error; only `st_op`=2'b11 sets `st_err`.

## Timing
- **Reset values.** On `rst` assertion, immediately and asynchronously:
  - state=IDLE, so `st_ready`=1;
  - `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0;
  - `st_done`=0, `st_err`=0.
- **Reset mid-beat** abandons the store. No `st_done` follows, and no further beat is issued.
- **Aligned, zero-wait memory:**
  - accept at edge 0;
  - `mem_req` high in cycle 1 with `mem_ack`=1;
  - `st_done` in cycle 2;
  - `st_ready` high again in cycle 3.
  - Throughput is 1 store per 3 cycles.
- **Spanning store** adds 1 cycle plus the wait cycles of beat 1.
- **Wait states.** Each wait cycle (`mem_req`=1, `mem_ack`=0) extends the current state by 1 cycle.
- **Illegal op:** accept at edge 0, `st_done`=`st_err`=1 in cycle 1, IDLE in cycle 2.
- **Busy.** `st_ready`=0 in REQ0/REQ1/RESP; `st_valid` is ignored there.
- **Back-to-back requests.** A request held with `st_valid` during RESP is accepted in the following IDLE cycle.

## Test plan
- **SB, zero-wait.** SB `st_addr`=0x0000_0103, `st_data`=0x1234_56A7, immediate ack → single beat: `mem_addr`=0x100, `mem_wdata`=0xA700_0000, `mem_wstrb`=4'b1000. `st_done` 2 cycles after accept, `st_err`=0.
- **SH, spanning.** SH `st_addr`=0x203, `st_data`=0xFFFF_BEEF → beat 0: 0x200 / 0xEF00_0000 / 4'b1000. Beat 1: 0x204 / 0x0000_00BE / 4'b0001. Exactly one `st_done`.
- **SW, spanning with wait states.** SW `st_addr`=0x102, `st_data`=0xAABB_CCDD, `mem_ack` delayed 3 cycles on beat 0 → beat 0 (0x100 / 0xCCDD_0000 / 4'b1100) held stable for 4 cycles. Beat 1: 0x104 / 0x0000_AABB / 4'b0011.
- **Address wrap.** SW `st_addr`=0xFFFF_FFFE → beat 0 at 0xFFFF_FFFC, strobes 4'b1100. Beat 1 at 0x0000_0000, strobes 4'b0011.
- **Illegal op.** `st_op`=2'b11 → `mem_req` never asserts. `st_done`=`st_err`=1 for one cycle, 1 cycle after accept.
- **Reset mid-beat.** Assert `rst` while `mem_req`=1 in REQ1 → all outputs at reset values within the same cycle. No `st_done`. After release, a new aligned SW at 0x40 completes normally.
